// File: rtl/memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_pkg                                                           |
// | Shared defaults, depth constant and FSM state type for memory.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package memory_pkg;

    localparam int c_addr_w = 7;
    localparam int c_data_w = 8;
    localparam int c_depth  = 2 ** c_addr_w;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A request is legal only when exactly one mode bit is set.
    function automatic logic is_legal_req(input logic en, input logic rd, input logic wr);
        return en && (rd ^ wr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_array                                                         |
// | Single-port-write / registered-read storage, 2**ADDR_W words.        |
// | MEMORY_CLEAR_ON_RESET_EN adds a reset that zeroes every word.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module memory_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
`ifdef MEMORY_CLEAR_ON_RESET_EN
    input  logic              rst,
`endif
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

`ifdef MEMORY_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory                                                               |
// | Handshaked single-word read/write memory: IDLE -> BUSY -> DONE.      |
// | Optional macro MEMORY_CLEAR_ON_RESET_EN clears contents on rst.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module memory
    import memory_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] output_data,
    output logic              ready
);

    state_t            r_state;
    logic              r_is_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept = (r_state == IDLE) && is_legal_req(en, read, write);
    // Gating with rst aborts a write that is in BUSY when reset arrives.
    assign w_we     = (r_state == BUSY) && r_is_write && !rst;

    // The array read is launched on the accepting edge so its registered
    // data is ready for output_data at the end of BUSY.
    memory_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
`ifdef MEMORY_CLEAR_ON_RESET_EN
        .rst   (rst),
`endif
        .we    (w_we),
        .waddr (r_addr),
        .wdata (r_wdata),
        .re    (w_accept),
        .raddr (address),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            output_data <= '0;
            ready       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_write <= write;
                        r_addr     <= address;
                        r_wdata    <= input_data;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!r_is_write) begin
                        output_data <= w_rdata;
                    end
                    ready   <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    if (!en) begin
                        ready   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    ready   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory                                                            |
// | Directed self-checking bench for memory.                             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_memory;

    logic       clk;
    logic       rst;
    logic       en;
    logic       read;
    logic       write;
    logic [6:0] address;
    logic [7:0] input_data;
    logic [7:0] output_data;
    logic       ready;

    int n_checks = 0;
    int n_fail   = 0;

    memory u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .read        (read),
        .write       (write),
        .address     (address),
        .input_data  (input_data),
        .output_data (output_data),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access with en held for a single cycle; inputs are scrambled
    // after acceptance so the captured copies must carry the access.
    task automatic access(input logic w, input logic [6:0] a, input logic [7:0] d);
        en = 1'b1; write = w; read = !w; address = a; input_data = d;
        step();
        chk("acc_busy_ready", {31'd0, ready}, 32'd0);
        en = 1'b0; read = w; write = !w; address = ~a; input_data = ~d;
        step();
        chk("acc_done_ready", {31'd0, ready}, 32'd1);
        read = 1'b0; write = 1'b0;
        step();
        chk("acc_idle_ready", {31'd0, ready}, 32'd0);
    endtask

    logic [7:0] exp_v;

    initial begin
        rst = 1'b1; en = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; input_data = '0;
        step();
        step();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_out", {24'd0, output_data}, 32'h00);
        rst = 1'b0;
        step();

        // Write 0xFF to address 1 with en held 3 cycles
        en = 1'b1; write = 1'b1; address = 7'd1; input_data = 8'hFF;
        step();
        chk("wr_busy_ready", {31'd0, ready}, 32'd0);
        step();
        chk("wr_done_ready", {31'd0, ready}, 32'd1);
        step();
        chk("wr_hold_ready", {31'd0, ready}, 32'd1);
        chk("wr_out_unchanged", {24'd0, output_data}, 32'h00);
        en = 1'b0; write = 1'b0;
        step();
        chk("wr_idle_ready", {31'd0, ready}, 32'd0);

        // Read address 1 with en held; DONE must not re-trigger
        en = 1'b1; read = 1'b1; address = 7'd1;
        step();
        chk("rd_busy_ready", {31'd0, ready}, 32'd0);
        step();
        chk("rd_done_ready", {31'd0, ready}, 32'd1);
        chk("rd_data", {24'd0, output_data}, 32'hFF);
        step();
        step();
        chk("rd_hold_ready", {31'd0, ready}, 32'd1);
        en = 1'b0; read = 1'b0;
        step();
        chk("rd_idle_ready", {31'd0, ready}, 32'd0);
        chk("rd_data_hold", {24'd0, output_data}, 32'hFF);

        // Illegal mode for 4 cycles
        en = 1'b1; read = 1'b1; write = 1'b1; address = 7'd1; input_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("illegal_ready", {31'd0, ready}, 32'd0);
        end
        en = 1'b0; read = 1'b0; write = 1'b0;
        step();
        chk("illegal_out", {24'd0, output_data}, 32'hFF);
        access(1'b0, 7'd1, 8'h00);
        chk("illegal_mem", {24'd0, output_data}, 32'hFF);

        // Early en drop on read of address 5
        access(1'b1, 7'd5, 8'h3C);
        chk("wr5_out_unchanged", {24'd0, output_data}, 32'hFF);
        access(1'b0, 7'd5, 8'h00);
        chk("early_drop_data", {24'd0, output_data}, 32'h3C);

        // Reset during BUSY of a write
        access(1'b1, 7'd9, 8'h11);
        en = 1'b1; write = 1'b1; address = 7'd9; input_data = 8'hAA;
        step();
        rst = 1'b1; en = 1'b0; write = 1'b0;
        step();
        chk("rst_busy_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy_out", {24'd0, output_data}, 32'h00);
        rst = 1'b0;
        step();
        access(1'b0, 7'd9, 8'h00);
`ifdef MEMORY_CLEAR_ON_RESET_EN
        exp_v = 8'h00;
`else
        exp_v = 8'h11;
`endif
        chk("rst_abort_data", {24'd0, output_data}, {24'd0, exp_v});

        // Full sweep
        for (int a = 0; a < 128; a++) begin
            access(1'b1, 7'(a), 8'(a) ^ 8'h55);
        end
        for (int a = 0; a < 128; a++) begin
            access(1'b0, 7'(a), 8'h00);
            chk($sformatf("sweep_%0d", a), {24'd0, output_data}, {24'd0, 8'(a) ^ 8'h55});
        end

        // Contents across reset
        access(1'b1, 7'd127, 8'h7E);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("clr_out_reset", {24'd0, output_data}, 32'h00);
        access(1'b0, 7'd127, 8'h00);
`ifdef MEMORY_CLEAR_ON_RESET_EN
        exp_v = 8'h00;
`else
        exp_v = 8'h7E;
`endif
        chk("clr_data", {24'd0, output_data}, {24'd0, exp_v});

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width; depth SHALL be 2**ADDR_W (128 words).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 en  input  1  SHALL request an access; it is sampled on the rising edge of clk.
REQ-006 read  input  1  SHALL select read mode.
REQ-007 write  input  1  SHALL select write mode.
REQ-008 address  input  ADDR_W  SHALL be the word address.
REQ-009 input_data  input  DATA_W  SHALL be the write data.
REQ-010 output_data  output  DATA_W  SHALL be the registered read data.
REQ-011 ready  output  1  SHALL signal access completion.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE, and SHALL leave reset in IDLE.
REQ-013 In IDLE, en=1 with exactly one of read/write high SHALL capture address, input_data and mode, then move to BUSY.
REQ-014 In IDLE, en=1 with read=write=1, or read=write=0, SHALL be ignored and the state SHALL remain IDLE.
REQ-015 BUSY SHALL last exactly one cycle.
- Write: the array SHALL be updated at the captured address.
- Read: output_data SHALL be loaded from the captured address.
- The next state SHALL be DONE.
REQ-016 Once accepted, an access SHALL complete even if en, read, write, address or input_data change or en drops.
REQ-017 ready SHALL be 1 only in DONE: 2 cycles after the accepting edge.
REQ-018 DONE SHALL be held while en=1; the FSM SHALL return to IDLE on the first edge with en=0, so ready is high for at least one cycle.
REQ-019 A new access SHALL require a return to IDLE, so holding en high never re-triggers.
REQ-020 output_data SHALL change only on read completion and SHALL otherwise hold its last value; writes SHALL NOT alter it.
REQ-021 A read of an address SHALL return the most recent completed write to it.

Reset
REQ-022 rst SHALL take priority over all other inputs.
REQ-023 rst SHALL force state=IDLE, ready=0 and output_data=0.
REQ-024 rst asserted during BUSY SHALL abort the access; a pending write SHALL NOT be committed.
REQ-025 Array contents SHALL be unaffected by rst unless REQ-026 applies.

Configuration
REQ-026 With macro MEMORY_CLEAR_ON_RESET_EN defined, rst SHALL zero all 2**ADDR_W words in the same cycle.
REQ-027 Without MEMORY_CLEAR_ON_RESET_EN, contents SHALL be retained across rst and SHALL be undefined after power-up.

Structure
REQ-028 Package memory_pkg SHALL hold the ADDR_W and DATA_W defaults, the DEPTH constant and the state enum type.
REQ-029 Storage SHALL be a sub-module memory_array with one synchronous write port and one registered read port, instantiated once.
REQ-030 The FSM, capture registers and output registers SHALL reside in memory.

Verification
REQ-031 Write then read:
- Stimulus: rst, then write=1, address=1, input_data=0xFF, en=1 for 3 cycles, then en=0; read=1, address=1, en=1.
- Required: ready=1 two cycles after each accepting edge; output_data=0xFF after the read.
REQ-032 Illegal mode: read=write=1 with en=1 for 4 cycles SHALL keep ready=0 and leave memory and output_data unchanged.
REQ-033 Early en drop: en=1 for 1 cycle on a read of address 5 (holding 0x3C) SHALL still give ready=1 for one cycle and output_data=0x3C.
REQ-034 Reset during BUSY of a write of 0xAA to address 9 (old value 0x11) SHALL give ready=0 and output_data=0; a subsequent read of address 9 SHALL return 0x11.
REQ-035 Full sweep: writing address^0x55 to all 128 addresses, then reading them back, SHALL match for every address, including 0 and 127.
REQ-036 With MEMORY_CLEAR_ON_RESET_EN: write 0x7E to address 127, apply rst, then read address 127 -> output_data=0x00; without the macro -> 0x7E.
